// File: rtl/prog_clk_divider.sv
// prog_clk_divider: programmable clock-enable divider with req/ack ratio reload at period boundaries.
// Define CLKDIV_PCNT_EN to add the 16-bit completed-period counter output period_cnt.
module prog_clk_divider #(
  parameter int WIDTH = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             load_req,
  output logic             load_ack,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
`ifdef CLKDIV_PCNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
  typedef enum logic [1:0] {STOP, RUN, PEND} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] cnt, cnt_nx, ratio, ratio_nx, pend_val, pend_val_nx;
  logic apply, pending_nx, clk_out_nx, tick_nx;
  // A stopped divider applies a pending ratio immediately; a running one waits for the last count.
  always_comb begin
    apply = pending && (!en || (state != STOP && cnt == ratio - ONE));
    cnt_nx = (en && state != STOP && cnt != ratio - ONE) ? cnt + ONE : '0;
    ratio_nx = apply ? pend_val : ratio;
    pend_val_nx = load_req ? ((div_val < TWO) ? TWO : div_val) : pend_val;
    pending_nx = load_req || (pending && !apply);
    state_nx = !en ? STOP : pending_nx ? PEND : RUN;
    clk_out_nx = en && (cnt_nx < (ratio_nx >> 1));
    tick_nx = en && (cnt_nx == ratio_nx - ONE);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= STOP;
      cnt <= '0;
      ratio <= WIDTH'(DEF_DIV);
      pend_val <= '0;
      pending <= 1'b0;
      load_ack <= 1'b0;
      clk_out <= 1'b0;
      tick <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      ratio <= ratio_nx;
      pend_val <= pend_val_nx;
      pending <= pending_nx;
      load_ack <= apply;
      clk_out <= clk_out_nx;
      tick <= tick_nx;
    end
  end
`ifdef CLKDIV_PCNT_EN
  always_ff @(posedge clk) begin
    if (!rst) period_cnt <= '0;
    else if (tick) period_cnt <= period_cnt + 16'd1;
  end
`endif
endmodule
